// File: rtl/pci_target_ctrl.sv
// pci_target_ctrl
// Target-side sequencer for a PCI device that exposes a config space and
// four I/O BARs through one read-back mux. It watches FRAME#/IRDY#, decodes
// the address phase, drives DEVSEL#/TRDY#/STOP#, and produces the mux selects,
// the AD direction control and the read/write strobes. Only one data phase
// is accepted per transaction; bursts are disconnected with data.
//
// Ports:
//   clk, rst_n            PCI clock (rising edge), async active-low PCI RST#
//   frame_n, irdy_n       master framing / ready
//   idsel                 config-space chip select
//   cbe_n[3:0]            command (address phase) / byte enables (data phase)
//   ad_in[31:0]           AD input path
//   bar0..bar3[31:0]      I/O BAR bases from config space
//   io_en                 command register I/O Space enable
//   devsel_n, trdy_n, stop_n, tctl_oe   registered target control + its OE
//   control               AD direction: 0 drives read data, 1 leaves AD input
//   is_config_space, is_io_space0..3    mux selects (zero- or one-hot)
//   addr_out, cmd_out     latched address and command of the address phase
//   be_out                latched active-high byte enables of a write phase
//   rd_strobe, wr_strobe  one-cycle completion pulses
module pci_target_ctrl #(
  parameter int IO_SIZE_LOG2 = 3,
  parameter int NUM_IO       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic        idsel,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad_in,
  input  logic [31:0] bar0,
  input  logic [31:0] bar1,
  input  logic [31:0] bar2,
  input  logic [31:0] bar3,
  input  logic        io_en,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n,
  output logic        tctl_oe,
  output logic        control,
  output logic        is_config_space,
  output logic        is_io_space0,
  output logic        is_io_space1,
  output logic        is_io_space2,
  output logic        is_io_space3,
  output logic [31:0] addr_out,
  output logic [3:0]  cmd_out,
  output logic [3:0]  be_out,
  output logic        rd_strobe,
  output logic        wr_strobe
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_RDATA  = 3'd2;
  localparam logic [2:0] S_WDATA  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_END    = 3'd5;
  localparam logic [2:0] S_SKIP   = 3'd6;

  // Only address bits above the BAR window take part in the I/O compare.
  localparam logic [31:0] IO_MASK = ~((32'd1 << IO_SIZE_LOG2) - 32'd1);

  logic [2:0]        state;
  logic              frame_q;
  logic [3:0]        cmd_now;
  logic              addr_phase;
  logic              cfg_hit;
  logic              io_cmd;
  logic [NUM_IO-1:0] io_hit;
  logic [NUM_IO-1:0] io_sel;
  logic              any_hit;

  assign cmd_now    = ~cbe_n;
  assign addr_phase = ~frame_n & frame_q;

  // Config read 1010 / write 1011 share [3:1]; likewise I/O 0010 / 0011.
  assign cfg_hit = idsel & (ad_in[1:0] == 2'b00) & (cmd_now[3:1] == 3'b101);
  assign io_cmd  = (cmd_now[3:1] == 3'b001) & io_en;

  assign io_hit[0] = io_cmd & (((ad_in ^ bar0) & IO_MASK) == 32'd0);
  assign io_hit[1] = io_cmd & (((ad_in ^ bar1) & IO_MASK) == 32'd0);
  assign io_hit[2] = io_cmd & (((ad_in ^ bar2) & IO_MASK) == 32'd0);
  assign io_hit[3] = io_cmd & (((ad_in ^ bar3) & IO_MASK) == 32'd0);

  // Overlapping BARs resolve to the lowest index so the mux stays one-hot.
  // Config and I/O commands never match together, so config needs no masking.
  assign io_sel[0] = io_hit[0];
  assign io_sel[1] = io_hit[1] & ~io_hit[0];
  assign io_sel[2] = io_hit[2] & ~(|io_hit[1:0]);
  assign io_sel[3] = io_hit[3] & ~(|io_hit[2:0]);

  assign any_hit = cfg_hit | (|io_hit);

  // Single sequencer: every output is registered and updated on the edge
  // that moves the FSM into the state where that value belongs, so the
  // control pins and mux selects change cleanly on clock edges only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      frame_q         <= 1'b1;
      devsel_n        <= 1'b1;
      trdy_n          <= 1'b1;
      stop_n          <= 1'b1;
      tctl_oe         <= 1'b0;
      control         <= 1'b1;
      is_config_space <= 1'b0;
      is_io_space0    <= 1'b0;
      is_io_space1    <= 1'b0;
      is_io_space2    <= 1'b0;
      is_io_space3    <= 1'b0;
      addr_out        <= 32'd0;
      cmd_out         <= 4'd0;
      be_out          <= 4'd0;
      rd_strobe       <= 1'b0;
      wr_strobe       <= 1'b0;
    end else begin
      frame_q   <= frame_n;
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;

      if (addr_phase) begin
        addr_out <= ad_in;
        cmd_out  <= cmd_now;
      end

      case (state)
        S_IDLE: begin
          if (addr_phase) begin
            if (any_hit) begin
              state           <= S_DECODE;
              devsel_n        <= 1'b0;
              tctl_oe         <= 1'b1;
              control         <= 1'b1;
              is_config_space <= cfg_hit;
              is_io_space0    <= io_sel[0];
              is_io_space1    <= io_sel[1];
              is_io_space2    <= io_sel[2];
              is_io_space3    <= io_sel[3];
            end else begin
              state <= S_SKIP;
            end
          end
        end

        // Turnaround cycle. A master still holding FRAME# here wants a burst,
        // so STOP# goes out with TRDY# to disconnect after this data phase.
        S_DECODE: begin
          trdy_n <= 1'b0;
          stop_n <= frame_n;
          if (cmd_out[0] == 1'b0) begin
            state   <= S_RDATA;
            control <= 1'b0;
          end else begin
            state   <= S_WDATA;
            control <= 1'b1;
          end
        end

        S_RDATA, S_WDATA: begin
          if (!irdy_n) begin
            if (state == S_RDATA) begin
              rd_strobe <= 1'b1;
            end else begin
              wr_strobe <= 1'b1;
              be_out    <= ~cbe_n;
            end
            trdy_n  <= 1'b1;
            control <= 1'b1;
            if (frame_n) begin
              state           <= S_END;
              devsel_n        <= 1'b1;
              stop_n          <= 1'b1;
              is_config_space <= 1'b0;
              is_io_space0    <= 1'b0;
              is_io_space1    <= 1'b0;
              is_io_space2    <= 1'b0;
              is_io_space3    <= 1'b0;
            end else begin
              state  <= S_HOLD;
              stop_n <= 1'b0;
            end
          end
        end

        S_HOLD: begin
          if (frame_n) begin
            state           <= S_END;
            devsel_n        <= 1'b1;
            stop_n          <= 1'b1;
            is_config_space <= 1'b0;
            is_io_space0    <= 1'b0;
            is_io_space1    <= 1'b0;
            is_io_space2    <= 1'b0;
            is_io_space3    <= 1'b0;
          end
        end

        // Control pins were driven high for this cycle; now release them.
        S_END: begin
          state   <= S_IDLE;
          tctl_oe <= 1'b0;
        end

        S_SKIP: begin
          if (frame_n && irdy_n) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
